// File: rtl/vdas_link_pkg.sv
// Shared types and constants for the acquisition-to-host serial link.
package vdas_link_pkg;

  localparam int MAX_CH = 16;
  localparam logic [3:0] HDR_MARK = 4'hA;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_LATCH,
    ST_HDR,
    ST_DATA
  } state_t;

  function automatic int byte_count(input int nbits);
    return (nbits + 7) / 8;
  endfunction

endpackage

// File: rtl/queue_drain_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request after last_grant, searching cyclically mod NCH.
module rr_pick #(
  parameter int NCH = 4,
  parameter int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] req,
  input  logic [CW-1:0]  last_grant,
  output logic           vld,
  output logic [CW-1:0]  idx
);

  int cand;

  always_comb begin
    vld  = 1'b0;
    idx  = '0;
    cand = 0;
    // offset NCH lands back on last_grant itself, so it is the lowest priority
    for (int off = 1; off <= NCH; off++) begin
      cand = (int'(last_grant) + off) % NCH;
      if (!vld && req[CW'(cand)]) begin
        vld = 1'b1;
        idx = CW'(cand);
      end
    end
  end

endmodule

// File: rtl/queue_drain_arbiter.sv
// Round-robin drain of NCH sample FIFOs into a byte stream: header {A, ch} then word bytes MSB first.
// Grant to first tx_valid is 3 cycles; tx_data/tx_valid hold while tx_ready is low.
module queue_drain_arbiter
  import vdas_link_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int NBITS = 8
) (
  input  logic                 ck,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NCH-1:0]       q_em,
  input  logic [NCH*NBITS-1:0] q_data,
  output logic [NCH-1:0]       q_pp,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy
);

  localparam int NBYTES   = byte_count(NBITS);
  localparam int SW       = NBYTES * 8;
  localparam int CW       = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int HDR_CH_W = $clog2(MAX_CH);
  localparam logic [CW-1:0] LAST_CH = CW'(NCH - 1);

  state_t          state, state_nxt;
  logic [CW-1:0]   cur_ch;
  logic [CW-1:0]   last_grant;
  logic [CW-1:0]   pick_idx;
  logic            pick_vld;
  logic [SW-1:0]   shreg;
  logic [2:0]      byte_cnt;
  logic            tx_fire;

  rr_pick #(.NCH(NCH), .CW(CW)) u_pick (
    .req        (~q_em),
    .last_grant (last_grant),
    .vld        (pick_vld),
    .idx        (pick_idx)
  );

  assign tx_fire = tx_valid && tx_ready;
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge ck) begin
    if (rst) begin
      state      <= ST_IDLE;
      cur_ch     <= '0;
      last_grant <= LAST_CH;
      shreg      <= '0;
      byte_cnt   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (en && pick_vld) cur_ch <= pick_idx;
        end
        ST_LATCH: begin
          // out register already holds the popped word after the POP edge
          shreg      <= SW'(q_data[int'(cur_ch)*NBITS +: NBITS]);
          last_grant <= cur_ch;
        end
        ST_HDR: begin
          if (tx_fire) byte_cnt <= 3'(NBYTES - 1);
        end
        ST_DATA: begin
          if (tx_fire && byte_cnt != '0) begin
            shreg    <= shreg << 8;
            byte_cnt <= byte_cnt - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    q_pp      = '0;
    tx_valid  = 1'b0;
    tx_data   = '0;
    case (state)
      ST_IDLE: begin
        if (en && pick_vld) state_nxt = ST_POP;
      end
      ST_POP: begin
        q_pp[cur_ch] = 1'b1;
        state_nxt    = ST_LATCH;
      end
      ST_LATCH: begin
        state_nxt = ST_HDR;
      end
      ST_HDR: begin
        tx_valid = 1'b1;
        tx_data  = {HDR_MARK, HDR_CH_W'(cur_ch)};
        if (tx_ready) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        tx_valid = 1'b1;
        tx_data  = shreg[SW-1 -: 8];
        if (tx_ready && byte_cnt == '0) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_queue_drain_arbiter.sv
// Bench: three arbiters (4x8, 4x12, 3x8) sharing control inputs, each fed by behavioural FIFOs.
module tb_queue_drain_arbiter;

  logic ck = 1'b0;
  always #5 ck = ~ck;

  logic rst, en, tx_ready;

  logic [3:0]  a_em, a_pp;
  logic [31:0] a_data;
  logic [7:0]  a_tx;
  logic        a_vld, a_busy;

  logic [3:0]  b_em, b_pp;
  logic [47:0] b_data;
  logic [7:0]  b_tx;
  logic        b_vld, b_busy;

  logic [2:0]  c_em, c_pp;
  logic [23:0] c_data;
  logic [7:0]  c_tx;
  logic        c_vld, c_busy;

  queue_drain_arbiter #(.NCH(4), .NBITS(8)) u_a (
    .ck(ck), .rst(rst), .en(en), .q_em(a_em), .q_data(a_data), .q_pp(a_pp),
    .tx_data(a_tx), .tx_valid(a_vld), .tx_ready(tx_ready), .busy(a_busy));

  queue_drain_arbiter #(.NCH(4), .NBITS(12)) u_b (
    .ck(ck), .rst(rst), .en(en), .q_em(b_em), .q_data(b_data), .q_pp(b_pp),
    .tx_data(b_tx), .tx_valid(b_vld), .tx_ready(tx_ready), .busy(b_busy));

  queue_drain_arbiter #(.NCH(3), .NBITS(8)) u_c (
    .ck(ck), .rst(rst), .en(en), .q_em(c_em), .q_data(c_data), .q_pp(c_pp),
    .tx_data(c_tx), .tx_valid(c_vld), .tx_ready(tx_ready), .busy(c_busy));

  // behavioural FIFOs: [dut][channel]
  logic [31:0] mem [3][4][64];
  int          wr  [3][4];
  int          rd  [3][4];
  logic [31:0] fout[3][4];
  logic [3:0]  pp_all[3];
  int          pp_cnt[3];
  logic [3:0]  pp_last[3];
  int          underflow = 0;
  int          multi_pp  = 0;

  int n_chk  = 0;
  int n_pass = 0;

  always_comb begin
    pp_all[0] = a_pp;
    pp_all[1] = b_pp;
    pp_all[2] = {1'b0, c_pp};
    for (int i = 0; i < 4; i++) begin
      a_em[i]            = (wr[0][i] == rd[0][i]);
      a_data[i*8 +: 8]   = fout[0][i][7:0];
      b_em[i]            = (wr[1][i] == rd[1][i]);
      b_data[i*12 +: 12] = fout[1][i][11:0];
    end
    for (int i = 0; i < 3; i++) begin
      c_em[i]          = (wr[2][i] == rd[2][i]);
      c_data[i*8 +: 8] = fout[2][i][7:0];
    end
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      pp_cnt[d]  = 0;
      pp_last[d] = '0;
      for (int i = 0; i < 4; i++) begin
        wr[d][i]   = 0;
        rd[d][i]   = 0;
        fout[d][i] = '0;
      end
    end
  end

  always @(posedge ck) begin
    for (int d = 0; d < 3; d++) begin
      if ($countones(pp_all[d]) > 1) multi_pp <= multi_pp + 1;
      if (pp_all[d] != '0) begin
        pp_cnt[d]  <= pp_cnt[d] + $countones(pp_all[d]);
        pp_last[d] <= pp_all[d];
      end
      for (int i = 0; i < 4; i++) begin
        if (pp_all[d][i]) begin
          if (wr[d][i] == rd[d][i]) underflow <= underflow + 1;
          fout[d][i] <= mem[d][i][rd[d][i]];
          rd[d][i]   <= rd[d][i] + 1;
        end
      end
    end
  end

  task automatic push(input int d, input int ch, input logic [31:0] w);
    mem[d][ch][wr[d][ch]] = w;
    wr[d][ch] = wr[d][ch] + 1;
  endtask

  task automatic sample(input int d, output logic v, output logic [7:0] x, output logic b);
    case (d)
      0:       begin v = a_vld; x = a_tx; b = a_busy; end
      1:       begin v = b_vld; x = b_tx; b = b_busy; end
      default: begin v = c_vld; x = c_tx; b = c_busy; end
    endcase
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // waits for the next accepted byte; sampled on the falling edge before the accepting rise
  task automatic get_byte(input int d, input string name, output logic [7:0] b, output int waited);
    logic v, bz;
    logic [7:0] x;
    bit got;
    got = 0; waited = 0; b = '0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge ck);
      waited++;
      sample(d, v, x, bz);
      if (v && tx_ready && bz) begin
        got = 1;
        b   = x;
      end
    end
    if (!got) begin
      n_chk++;
      $display("FAIL %s: no byte within 40 cycles", name);
    end
  endtask

  task automatic expect_pkt(input int d, input string name, input logic [7:0] hdr, input logic [7:0] dat);
    logic [7:0] b;
    int w;
    get_byte(d, {name, "_hdr"}, b, w);
    check({name, "_hdr"}, b, hdr);
    get_byte(d, {name, "_dat"}, b, w);
    check({name, "_dat"}, b, dat);
  endtask

  // holds tx_ready low for 5 sampled cycles of a byte, then accepts it
  task automatic bp_byte(input int d, input string name, input logic [7:0] exp);
    logic v, bz;
    logic [7:0] x;
    bit got;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge ck);
      sample(d, v, x, bz);
      if (v) got = 1;
    end
    if (!got) begin
      n_chk++;
      $display("FAIL %s: tx_valid never rose", name);
    end else begin
      for (int i = 0; i < 5; i++) begin
        check(name, {23'd0, v, x}, {23'd0, 1'b1, exp});
        if (i < 4) begin
          @(negedge ck);
          sample(d, v, x, bz);
        end
      end
    end
    tx_ready = 1'b1;
    @(negedge ck);
    tx_ready = 1'b0;
  endtask

  typedef struct {
    int          ch;
    logic [31:0] word;
    logic [7:0]  hdr;
    logic [7:0]  dat;
    logic [3:0]  pp;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [7:0] b;
    logic v, bz;
    logic [7:0] x;
    int w, p0;

    vecs[0] = '{2, 32'h5C, 8'hA2, 8'h5C, 4'b0100};
    vecs[1] = '{1, 32'h00, 8'hA1, 8'h00, 4'b0010};
    vecs[2] = '{3, 32'hFF, 8'hA3, 8'hFF, 4'b1000};
    vecs[3] = '{0, 32'h81, 8'hA0, 8'h81, 4'b0001};

    rst = 1'b1; en = 1'b0; tx_ready = 1'b1;
    repeat (3) @(negedge ck);
    check("rst_q_pp", {28'd0, a_pp}, 32'd0);
    check("rst_tx_valid", {31'd0, a_vld}, 32'd0);
    check("rst_tx_data", {24'd0, a_tx}, 32'd0);
    check("rst_busy", {29'd0, c_busy, b_busy, a_busy}, 32'd0);
    rst = 1'b0; en = 1'b1;

    // single-word packets, one channel at a time
    for (int i = 0; i < 4; i++) begin
      p0 = pp_cnt[0];
      push(0, vecs[i].ch, vecs[i].word);
      get_byte(0, "vec_hdr", b, w);
      check($sformatf("vec%0d_latency", i), w, 3);
      check($sformatf("vec%0d_hdr", i), {24'd0, b}, {24'd0, vecs[i].hdr});
      get_byte(0, "vec_dat", b, w);
      check($sformatf("vec%0d_dat", i), {24'd0, b}, {24'd0, vecs[i].dat});
      @(negedge ck);
      sample(0, v, x, bz);
      check($sformatf("vec%0d_idle", i), {30'd0, bz, v}, 32'd0);
      check($sformatf("vec%0d_pp_cnt", i), pp_cnt[0] - p0, 1);
      check($sformatf("vec%0d_pp_sel", i), {28'd0, pp_last[0]}, {28'd0, vecs[i].pp});
    end

    // round robin from reset priority
    rst = 1'b1; @(negedge ck); rst = 1'b0;
    for (int c = 0; c < 4; c++) push(0, c, 32'h10 + c);
    for (int k = 0; k < 4; k++)
      expect_pkt(0, $sformatf("rr%0d", k), 8'hA0 + 8'(k), 8'h10 + 8'(k));
    push(0, 0, 32'h14);
    expect_pkt(0, "rr_refill", 8'hA0, 8'h14);

    // backpressure on a two-data-byte word
    p0 = pp_cnt[1];
    tx_ready = 1'b0;
    push(1, 1, 32'hABC);
    bp_byte(1, "bp_hdr", 8'hA1);
    bp_byte(1, "bp_d0", 8'h0A);
    bp_byte(1, "bp_d1", 8'hBC);
    @(negedge ck);
    check("bp_busy_done", {31'd0, b_busy}, 32'd0);
    check("bp_pp_cnt", pp_cnt[1] - p0, 1);
    tx_ready = 1'b1;

    // enable gating
    rst = 1'b1; @(negedge ck); rst = 1'b0;
    p0 = pp_cnt[0];
    push(0, 0, 32'h21);
    push(0, 3, 32'h24);
    get_byte(0, "en_hdr0", b, w);
    check("en_hdr0", {24'd0, b}, 32'hA0);
    get_byte(0, "en_dat0", b, w);
    check("en_dat0", {24'd0, b}, 32'h21);
    en = 1'b0;
    repeat (10) @(negedge ck);
    check("en_off_pp", pp_cnt[0] - p0, 1);
    check("en_off_busy", {31'd0, a_busy}, 32'd0);
    en = 1'b1;
    expect_pkt(0, "en_next", 8'hA3, 8'h24);
    check("en_pp_total", pp_cnt[0] - p0, 2);

    // reset while in DATA; channel 0 had just been served
    push(0, 0, 32'h42);
    get_byte(0, "rm_hdr", b, w);
    check("rm_hdr", {24'd0, b}, 32'hA0);
    @(negedge ck);
    check("rm_in_data", {23'd0, a_vld, a_tx}, {23'd0, 1'b1, 8'h42});
    rst = 1'b1;
    @(negedge ck);
    check("rm_after_rst", {18'd0, a_pp, a_vld, a_busy, a_tx}, 32'd0);
    rst = 1'b0;
    push(0, 0, 32'h50);
    push(0, 1, 32'h51);
    expect_pkt(0, "rm_first", 8'hA0, 8'h50);
    expect_pkt(0, "rm_second", 8'hA1, 8'h51);

    // NCH=3 wrap-around
    rst = 1'b1; @(negedge ck); rst = 1'b0;
    for (int k = 0; k < 7; k++) push(2, k % 3, 32'h30 + k);
    for (int k = 0; k < 7; k++)
      expect_pkt(2, $sformatf("wrap%0d", k), 8'hA0 + 8'(k % 3), 8'h30 + 8'(k));

    repeat (3) @(negedge ck);
    check("no_underflow", underflow, 0);
    check("pp_onehot", multi_pp, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/queue_drain_arbiter.md
Name: queue_drain_arbiter

Overview:
- Round-robin scheduler that drains NCH sample FIFOs (the existing queue block, one per acquisition channel) into a single byte-wide serial transmit path.
- For each grant it pops one word from the selected FIFO and emits a framed packet: one header byte, then the data word as bytes, MSB first.
- Sits between the per-channel FIFOs and the UART transmitter on the host link.

Parameters:
- NCH, 4, number of channels/FIFOs; legal range 1..16.
- NBITS, 8, FIFO word width; legal range 1..32.
- NBYTES, derived localparam = ceil(NBITS/8), number of data bytes per packet.

Ports:
- ck  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  1 = new packets may start; 0 = current packet completes, then block idles.
- q_em  input  NCH  per-FIFO empty flags (bit i = FIFO i).
- q_data  input  NCH*NBITS  per-FIFO out registers; FIFO i occupies bits [i*NBITS +: NBITS].
- q_pp  output  NCH  per-FIFO pop strobes; at most one bit high, for one cycle.
- tx_data  output  8  byte to transmitter.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  transmitter accepts the byte on a cycle with tx_valid && tx_ready.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst=1 at a rising edge) returns the block to IDLE from any state, including mid-packet. The partial packet is abandoned.
- Reset values: q_pp=0, tx_valid=0, tx_data=0, busy=0, last_grant=NCH-1 (so channel 0 has first priority).
- FSM states and transitions:
  - IDLE: if en && any(!q_em), select the first non-empty channel searching cyclically from last_grant+1. Register it as cur_ch and go to POP. Otherwise stay in IDLE.
  - POP: drive q_pp[cur_ch]=1 combinationally for exactly this cycle; go to LATCH. The FIFO updates its out register on this edge.
  - LATCH: capture q_data slice of cur_ch into a shift register, zero-extended to NBYTES*8 bits. Set last_grant=cur_ch; go to HDR.
  - HDR: tx_valid=1, tx_data={4'hA, cur_ch zero-extended to 4 bits}. On handshake, set byte_cnt=NBYTES-1 and go to DATA.
  - DATA: tx_valid=1, tx_data=top byte of the shift register. On handshake: if byte_cnt==0 go to IDLE; else shift left by 8 and decrement byte_cnt.
- tx_data and tx_valid are registered or state-decoded and must stay stable while tx_valid && !tx_ready. tx_valid drops in IDLE, POP and LATCH.
- Fixed latency from IDLE grant to first tx_valid: 3 cycles (IDLE→POP→LATCH→HDR). Each byte takes ≥1 cycle. Best case is NBYTES+4 cycles per packet.
- q_em is sampled only in IDLE. The grant is never re-evaluated mid-packet, so a FIFO becoming empty or non-empty during a packet has no effect until the next IDLE.
- A pop is only issued to a channel that was non-empty at the grant. The controller is the only popper, so the FIFO cannot underflow.
- en deasserting mid-packet does not truncate the packet; the block finishes the packet and stays in IDLE.
- Fairness: after channel k is served, channel k+1 (mod NCH) has highest priority. With all FIFOs non-empty, service order is 0,1,…,NCH-1,0,…
- Wrap-around: the search index is computed mod NCH for non-power-of-two NCH, e.g. NCH=3 gives order 2→0.
- NCH=1: always grant channel 0; the header is 8'hA0.

Decomposition:
- Shared package vdas_link_pkg holds:
  - the state enumeration;
  - HDR_MARK = 4'hA;
  - the byte-count function ceil(NBITS/8);
  - MAX_CH = 16.
- One natural sub-module, rr_pick: combinational round-robin selector. Inputs are a request vector and last_grant; outputs are a valid flag and the granted index.

Test Plan:
- Single word: NCH=4, NBITS=8; load 0x5C into FIFO 2 only; en=1, tx_ready=1 → q_pp=4'b0100 for one cycle, then bytes 0xA2, 0x5C; busy low one cycle after 0x5C accepted.
- Round-robin: one word in each FIFO (0x10,0x11,0x12,0x13) → header order A0,A1,A2,A3, each followed by its word; then refill FIFO 0 only → A0 next.
- Backpressure: NBITS=12, word 0xABC in FIFO 1; hold tx_ready=0 for 5 cycles on each byte → tx_data stable at 0xA1, then 0x0A, then 0xBC; no extra q_pp pulses.
- Enable gating: words queued in FIFOs 0 and 3; drop en during FIFO 0's data byte → packet A0 completes; no further q_pp until en=1; next packet is A3.
- Reset mid-packet: assert rst for 1 cycle while in DATA → next cycle tx_valid=0, busy=0, q_pp=0; after release, channel 0 is served first if non-empty.
- Non-power-of-two wrap: NCH=3, all FIFOs non-empty for 7 packets → headers A0,A1,A2,A0,A1,A2,A0.
